config_chain_loader: RTL
========================

// Module: config_chain_loader
// PURPOSE
//  Sequencer for the CGRA configuration scan chain of ConfigCell stages. Accepts
//  configuration words over a valid/ready port, serialises them LSB-first onto
//  the chain input with one shift strobe per bit, and captures the bits leaving
//  the chain tail as readback words. Sits between the host-facing config port
//  and the head/tail of the chain. The strobe drives the chain clock gate.
// PARAMETERS
//  WORD_W     32  width of config/readback words
//  CHAIN_LEN  64  total bits in the chain (>=1)
//  DIV        1   cycles per shifted bit (>=1); strobe high 1 of every DIV cycles
//  RD_EN      1   1: emit readback words; 0: DRAIN state skipped, rd_valid tied 0
// PORTS
//  Config_Clock  in   1       sole clock, all logic on posedge
//  Config_Reset  in   1       synchronous, active-high reset
//  start         in   1       begin a full-chain load; ignored unless IDLE
//  abort         in   1       abandon load; highest priority after reset
//  busy          out  1       high in any state except IDLE
//  done          out  1       one-cycle pulse when the whole chain has been shifted
//  wr_data       in   WORD_W  config word; bit 0 shifted first
//  wr_valid      in   1       wr_data valid
//  wr_ready      out  1       high only in LOAD
//  rd_data       out  WORD_W  readback word; first bit captured in bit 0
//  rd_valid      out  1       high only in DRAIN
//  rd_ready      in   1       readback accepted
//  cfg_data      out  1       to ConfigIn of the chain head
//  cfg_shift_en  out  1       shift strobe / chain clock-gate enable
//  cfg_return    in   1       from ConfigOut of the chain tail
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, wr_ready, rd_valid, cfg_data, cfg_shift_en=0;
//   rd_data=0; bit and divider counters cleared. Reset mid-shift stops strobes
//   the next cycle. Chain contents are then undefined and need a full reload.
//  Word count = ceil(CHAIN_LEN/WORD_W). The last word carries CHAIN_LEN mod
//   WORD_W bits when nonzero. Its unused upper wr_data bits are ignored and its
//   unused upper rd_data bits read 0.
//  FSM (registered outputs derived from state):
//   IDLE : start -> LOAD, bits_left<=CHAIN_LEN.
//   LOAD : wr_ready=1. On wr_valid: sreg<=wr_data, nbits<=min(WORD_W,bits_left),
//          rb<=0, div_cnt<=0 -> SHIFT.
//   SHIFT: cfg_shift_en=1 in the cycle div_cnt==DIV-1, with cfg_data=sreg[0]
//          in that cycle. On that cycle:
//          - cfg_return (tail value before the shift edge) goes into rb[bit_idx];
//          - sreg>>=1; bits_left--, nbits--.
//          Otherwise cfg_data holds the bit pending for the next strobe.
//          nbits reaching 0 -> DRAIN (RD_EN=1); otherwise straight to the
//          DRAIN exit test.
//   DRAIN: rd_valid=1, rd_data=rb, held stable until rd_ready.
//          rd_valid&&rd_ready -> bits_left==0 ? DONE : LOAD.
//   DONE : done=1 for exactly one cycle -> IDLE.
//  Strobe spacing is exactly DIV cycles within a word. Between words, gaps are
//   set by the handshakes: at least 1 cycle in LOAD, plus DRAIN when RD_EN=1.
//  Exactly CHAIN_LEN strobes per completed load. The first bit sent ends at the
//   chain tail. Readback returns the pre-load contents, tail bit first.
//  abort in non-IDLE: next cycle IDLE. No done. Strobe, wr_ready and rd_valid
//   drop that cycle. Same-cycle start+abort in IDLE: abort wins (stay IDLE).
//  start while busy: ignored, no restart. wr_valid outside LOAD: not consumed.
// TESTING
//  1 CHAIN_LEN=40,WORD_W=32,DIV=1; words 0xDEADBEEF,0xA5, chain model preloaded
//    0x00_FFFF0000 -> 40 strobes, 32 back-to-back. Model=0xA5DEADBEEF; rd words
//    0xFFFF0000 then 0x00000000; one done pulse.
//  2 Same with rd_ready low 10 cycles in first DRAIN -> rd_data stable,
//    wr_ready low, no strobes during the stall; final model still 0xA5DEADBEEF.
//  3 DIV=4 -> strobes exactly 4 cycles apart inside a word. cfg_data equals the
//    expected bit on every strobe cycle.
//  4 abort after 17 strobes -> IDLE next cycle, busy=0, no done, no further
//    strobes. A new start gives a correct full load.
//  5 Config_Reset pulsed mid-SHIFT -> all outputs 0 next cycle. start during
//    busy and wr_valid in IDLE are both ignored; strobe count unchanged.
//  6 RD_EN=0,CHAIN_LEN=32 -> one word, rd_valid never high, done one cycle
//    after the 32nd strobe.

Source files
------------

// File: rtl/config_chain_loader.sv
// Loads a configuration scan chain one bit at a time from host words.
// Also returns the bits leaving the chain tail to the host as readback words.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64,
  parameter int DIV       = 1,
  parameter int RD_EN     = 1
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              cfg_data,
  output logic              cfg_shift_en,
  input  logic              cfg_return
);

  localparam int BL_W  = $clog2(CHAIN_LEN + 1);
  localparam int NB_W  = $clog2(WORD_W + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int DC_W  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [BL_W-1:0]   bits_left;
  logic [NB_W-1:0]   nbits;
  logic [IDX_W-1:0]  bit_idx;
  logic [DC_W-1:0]   div_cnt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] rb;
  logic              strobe;

  assign strobe = (state == S_SHIFT) && (div_cnt == DC_W'(DIV - 1));

  // All outputs decode registered state only, so nothing combinational reaches the chain gate.
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign wr_ready     = (state == S_LOAD);
  assign rd_valid     = (RD_EN != 0) && (state == S_DRAIN);
  assign rd_data      = rb;
  assign cfg_shift_en = strobe;
  assign cfg_data     = (state == S_SHIFT) && sreg[0];

  always_ff @(posedge Config_Clock) begin
    if (Config_Reset) begin
      state     <= S_IDLE;
      bits_left <= '0;
      nbits     <= '0;
      bit_idx   <= '0;
      div_cnt   <= '0;
      rb        <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            bits_left <= BL_W'(CHAIN_LEN);
          end
        end
        S_LOAD: begin
          if (wr_valid) begin
            sreg    <= wr_data;
            nbits   <= (int'(bits_left) < WORD_W) ? NB_W'(bits_left) : NB_W'(WORD_W);
            rb      <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (strobe) begin
            // cfg_return is the tail bit before this edge shifts the chain.
            rb[bit_idx] <= cfg_return;
            sreg        <= sreg >> 1;
            bits_left   <= bits_left - BL_W'(1);
            nbits       <= nbits - NB_W'(1);
            bit_idx     <= bit_idx + IDX_W'(1);
            div_cnt     <= '0;
            if (nbits == NB_W'(1)) begin
              if (RD_EN != 0)                  state <= S_DRAIN;
              else if (bits_left == BL_W'(1))  state <= S_DONE;
              else                             state <= S_LOAD;
            end
          end else begin
            div_cnt <= div_cnt + DC_W'(1);
          end
        end
        S_DRAIN: begin
          if (rd_ready) state <= (bits_left == '0) ? S_DONE : S_LOAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
